// File: rtl/cmp_share_pkg.sv
// Shared types for the comparator-sharing arbiter: FSM state encoding and
// default requester-index width.
package cmp_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int NUM_REQ_DFLT = 4;
  localparam int ID_W         = $clog2(NUM_REQ_DFLT);

endpackage

// File: rtl/cmp_share_arbiter_rr_pick.sv
// Round-robin picker: rotates the request vector so rr_ptr lands on bit 0,
// takes the lowest set bit, then rotates the index back. Purely combinational.
module rr_pick
  import cmp_share_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [$clog2(NUM_REQ)-1:0] rr_ptr,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       any
);

  localparam int PW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [PW-1:0]      offs;

  // rotate-right via double-width shift, then lowest-set-bit priority
  always_comb begin
    rot  = NUM_REQ'({req_valid, req_valid} >> rr_ptr);
    offs = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) offs = PW'(i);
    end
    any      = |rot;
    // NUM_REQ is a power of two, so the PW-bit add wraps modulo NUM_REQ
    grant_id = rr_ptr + offs;
    grant    = any ? (NUM_REQ'(1) << grant_id) : '0;
  end

endmodule

// File: rtl/cmp_share_arbiter.sv
// cmp_share_arbiter: one WIDTH-bit unsigned greater-than comparator shared by
// NUM_REQ requesters with round-robin arbitration and a registered response.
// Optional macro CMP_SHARE_ARBITER_EQ_EN adds a registered rsp_eq output.
//
//   state | meaning
//   IDLE  | offering a grant; accept latches operands and requester index
//   CMP   | comparing latched operands; result registered at the next edge
//   RESP  | result held on rsp_* until the consumer takes it
module cmp_share_arbiter
  import cmp_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output logic                       rsp_gt,
`ifdef CMP_SHARE_ARBITER_EQ_EN
  output logic                       rsp_eq,
`endif
  output logic [CNT_W-1:0]           txn_cnt
);

  localparam int RID_W = $clog2(NUM_REQ);

  state_e             state;
  logic [RID_W-1:0]   rr_ptr;
  logic [RID_W-1:0]   id_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [NUM_REQ-1:0] pick_grant;
  logic [RID_W-1:0]   pick_id;
  logic               pick_any;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rr_pick (
    .rr_ptr    (rr_ptr),
    .req_valid (req_valid),
    .grant     (pick_grant),
    .grant_id  (pick_id),
    .any       (pick_any)
  );

  // grant only while idle and out of reset
  assign req_ready = (rst_n && (state == IDLE)) ? pick_grant : '0;

  // FSM, operand capture, result registers and completion counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      id_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_gt    <= 1'b0;
`ifdef CMP_SHARE_ARBITER_EQ_EN
      rsp_eq    <= 1'b0;
`endif
      txn_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            a_q   <= req_a[int'(pick_id)*WIDTH +: WIDTH];
            b_q   <= req_b[int'(pick_id)*WIDTH +: WIDTH];
            id_q  <= pick_id;
            state <= CMP;
          end
        end
        CMP: begin
          rsp_gt    <= (a_q > b_q);
`ifdef CMP_SHARE_ARBITER_EQ_EN
          rsp_eq    <= (a_q == b_q);
`endif
          rsp_id    <= id_q;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= id_q + 1'b1;
            txn_cnt   <= txn_cnt + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Bench for cmp_share_arbiter (NUM_REQ=4, WIDTH=8, CNT_W=4 so the counter wraps).
module tb_cmp_share_arbiter;

  localparam int NR = 4;
  localparam int W  = 8;
  localparam int CW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NR-1:0]   req_valid;
  logic [NR*W-1:0] req_a;
  logic [NR*W-1:0] req_b;
  logic [NR-1:0]   req_ready;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [1:0]      rsp_id;
  logic            rsp_gt;
`ifdef CMP_SHARE_ARBITER_EQ_EN
  logic            rsp_eq;
`endif
  logic [CW-1:0]   txn_cnt;

  cmp_share_arbiter #(.NUM_REQ(NR), .WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_gt    (rsp_gt),
`ifdef CMP_SHARE_ARBITER_EQ_EN
    .rsp_eq    (rsp_eq),
`endif
    .txn_cnt   (txn_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    int id;
    bit gt;
    bit eq;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] a;
    logic [31:0] b;
    int          stall;
    int          exp_id;
    bit          exp_gt;
    bit          exp_eq;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out (t=%0t)", name, $time);
  endtask

  // reference round-robin: walk cyclically from ptr, first valid wins
  function automatic logic [3:0] model_pick(input int ptr, input logic [3:0] v);
    for (int k = 0; k < NR; k++) begin
      int idx;
      idx = (ptr + k) % NR;
      if (v[idx]) return 4'(1 << idx);
    end
    return 4'b0000;
  endfunction

  // protocol monitor / scoreboard consumer
  int m_state = 0;  // 0 idle, 1 cmp, 2 resp
  int m_ptr   = 0;
  int m_cnt   = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_txn_cnt", 32'(txn_cnt), 32'h0);
      m_state = 0;
      m_ptr   = 0;
      m_cnt   = 0;
    end else begin
      chk("txn_cnt", 32'(txn_cnt), 32'(m_cnt % 16));
      case (m_state)
        0: begin
          logic [3:0] g;
          g = model_pick(m_ptr, req_valid);
          chk("grant", 32'(req_ready), 32'(g));
          chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
          if (g != 4'b0000) m_state = 1;
        end
        1: begin
          chk("cmp_req_ready", 32'(req_ready), 32'h0);
          chk("cmp_rsp_valid", 32'(rsp_valid), 32'h0);
          m_state = 2;
        end
        default: begin
          chk("resp_req_ready", 32'(req_ready), 32'h0);
          chk("resp_rsp_valid", 32'(rsp_valid), 32'h1);
          if (sb.size() == 0) begin
            fail("sb_underflow");
          end else begin
            chk("rsp_id", 32'(rsp_id), 32'(sb[0].id));
            chk("rsp_gt", 32'(rsp_gt), 32'(sb[0].gt));
`ifdef CMP_SHARE_ARBITER_EQ_EN
            chk("rsp_eq", 32'(rsp_eq), 32'(sb[0].eq));
`endif
            if (rsp_ready) begin
              m_ptr   = (sb[0].id + 1) % NR;
              m_cnt   = m_cnt + 1;
              m_state = 0;
              void'(sb.pop_front());
            end
          end
        end
      endcase
    end
  end

  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail("accept_wait");
  endtask

  task automatic wait_sb_empty();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sb.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) fail("response_wait");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int last;
    int ids[5];
    bit gts[5];

    tbl[0] = '{4'b0001, 32'h0000_0080, 32'h0000_007F, 0,  0, 1'b1, 1'b0};
    tbl[1] = '{4'b0100, 32'h0055_0000, 32'h0055_0000, 0,  2, 1'b0, 1'b1};
    tbl[2] = '{4'b0011, 32'h0000_AA01, 32'h0000_0002, 0,  0, 1'b0, 1'b0};
    tbl[3] = '{4'b1001, 32'hFF00_0000, 32'h0000_0000, 10, 3, 1'b1, 1'b0};
    tbl[4] = '{4'b1111, 32'h0000_0000, 32'h0000_00FF, 0,  0, 1'b0, 1'b0};
    tbl[5] = '{4'b0110, 32'h0000_7F00, 32'h0000_8000, 0,  1, 1'b0, 1'b0};
    tbl[6] = '{4'b0010, 32'h0000_FE00, 32'h0000_FD00, 0,  1, 1'b1, 1'b0};

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_rsp_id", 32'(rsp_id), 32'h0);
    chk("reset_rsp_gt", 32'(rsp_gt), 32'h0);
    #1 rst_n = 1'b1;

    // table-driven single transactions
    for (int t = 0; t < 7; t++) begin
      @(posedge clk);
      #1;
      req_valid = tbl[t].valid;
      req_a     = tbl[t].a;
      req_b     = tbl[t].b;
      rsp_ready = (tbl[t].stall == 0);
      sb.push_back('{tbl[t].exp_id, tbl[t].exp_gt, tbl[t].exp_eq});
      wait_accept(ok);
      if (ok) chk("tbl_grant", 32'(req_ready), 32'(1 << tbl[t].exp_id));
      @(posedge clk);
      #1;
      req_valid = '0;
      req_a     = {$urandom(), $urandom()} >> 32;
      req_b     = $urandom();
      if (tbl[t].stall > 0) begin
        for (int j = 0; j < tbl[t].stall + 1; j++) begin
          @(posedge clk);
          #1;
          if (j == 3) req_valid = 4'b1000;
          if (j == 5) req_valid = 4'b0000;
        end
        rsp_ready = 1'b1;
      end
      wait_sb_empty();
    end

    // reset asserted while a comparison is in flight
    @(posedge clk);
    #1;
    req_valid = 4'b1000;
    req_a     = 32'hFF00_0000;
    wait_accept(ok);
    @(posedge clk);
    #2;
    rst_n     = 1'b0;
    sb.delete();
    req_valid = 4'b1111;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("midrst_req_ready", 32'(req_ready), 32'h0);
    chk("midrst_txn_cnt", 32'(txn_cnt), 32'h0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // four requesters continuously active, consumer always ready
    req_a     = 32'h3323_1303;
    req_b     = 32'h2020_2020;
    rsp_ready = 1'b1;
    ids = '{0, 1, 2, 3, 0};
    gts = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int k = 0; k < 5; k++) sb.push_back('{ids[k], gts[k], 1'b0});
    last = 0;
    for (int k = 0; k < 5; k++) begin
      wait_accept(ok);
      if (!ok) break;
      chk("stream_grant", 32'(req_ready), 32'(1 << ids[k]));
      if (k > 0) chk("stream_spacing", 32'(cyc - last), 32'd3);
      last = cyc;
    end
    @(posedge clk);
    #1 req_valid = '0;
    wait_sb_empty();
    chk("stream_txn_cnt", 32'(txn_cnt), 32'd5);

    // eleven more transactions to wrap the 4-bit counter
    for (int k = 0; k < 11; k++) begin
      @(posedge clk);
      #1;
      if (k == 10) chk("cnt_before_wrap", 32'(txn_cnt), 32'd15);
      req_valid = 4'(1 << (k % 4));
      req_a     = {4{8'(k)}};
      req_b     = {4{8'd5}};
      sb.push_back('{k % 4, (k > 5), (k == 5)});
      wait_accept(ok);
      @(posedge clk);
      #1 req_valid = '0;
      wait_sb_empty();
    end
    @(negedge clk);
    chk("cnt_wrapped", 32'(txn_cnt), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
